// File: rtl/fetch_unit.sv
// Program sequencer: loadable store, PC, {operand, opcode} issue with stall.
// Define LOOP_WRAP_EN to wrap the PC at the top of the store instead of halting.
module fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int OP_W   = 4,
  parameter logic [OP_W-1:0] HALT_OP = '1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     stall,
  input  logic                     jump_en,
  input  logic [ADDR_W-1:0]        jump_addr,
  input  logic                     prog_we,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [DATA_W+OP_W-1:0]   prog_data,
  output logic [ADDR_W-1:0]        count,
  output logic [DATA_W-1:0]        inX,
  output logic [OP_W-1:0]          insControle,
  output logic                     instr_valid,
  output logic                     halted
);

  localparam int W = DATA_W + OP_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

`ifdef LOOP_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALT
  } state_t;

  state_t state;

  logic [W-1:0] mem [2**ADDR_W];
  logic [W-1:0] word;
  logic         stopped;

  assign word    = mem[count];
  assign stopped = (state == IDLE) || (state == HALT);

  // Store is only writable while the sequencer is parked
  always_ff @(posedge clock) begin
    if (prog_we && stopped)
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      inX         <= '0;
      insControle <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run) begin
            state <= FETCH;
            count <= '0;
          end
        end
        FETCH: begin
          if (word[OP_W-1:0] == HALT_OP) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            inX         <= word[W-1:OP_W];
            insControle <= word[OP_W-1:0];
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (jump_en) begin
              count <= jump_addr;
              state <= FETCH;
            end else if (!WRAP && count == LAST) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              count <= count + 1'b1;
              state <= FETCH;
            end
          end
        end
        HALT: begin
          if (run) begin
            state  <= FETCH;
            count  <= '0;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed sequences, random vs model.
// Honours LOOP_WRAP_EN the same way the design does.
module tb_fetch_unit;

`ifdef LOOP_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       stall = 1'b0;
  logic       jump_en = 1'b0;
  logic [3:0] jump_addr = '0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [3:0] count;
  logic [3:0] inX;
  logic [3:0] insControle;
  logic       instr_valid;
  logic       halted;

  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .count       (count),
    .inX         (inX),
    .insControle (insControle),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] c,
                         input logic v, input logic h,
                         input logic [3:0] x, input logic [3:0] op);
    chk({nm, ".count"}, 32'(count), 32'(c));
    chk({nm, ".valid"}, 32'(instr_valid), 32'(v));
    chk({nm, ".halted"}, 32'(halted), 32'(h));
    chk({nm, ".inX"}, 32'(inX), 32'(x));
    chk({nm, ".op"}, 32'(insControle), 32'(op));
  endtask

  task automatic do_reset();
    run = 0; stall = 0; jump_en = 0; prog_we = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 0;
  endtask

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    logic       v;
    logic       h;
    logic [3:0] x;
    logic [3:0] op;
  } vec_t;

  vec_t vecs[6];

  // Behavioural reference: phase flags, a PC and a copy of the store
  logic [7:0] mm [16];
  bit         m_idle, m_fetch, m_valid, m_halt;
  logic [3:0] m_pc, m_x, m_op;

  task automatic model_step();
    logic [7:0] w;
    if (m_idle || m_halt) begin
      if (prog_we) mm[prog_addr] = prog_data;
      if (run) begin
        m_pc = 0; m_fetch = 1; m_idle = 0; m_halt = 0;
      end
    end else if (m_fetch) begin
      m_fetch = 0;
      w = mm[m_pc];
      if (w[3:0] == 4'hF) m_halt = 1;
      else begin
        m_x = w[7:4]; m_op = w[3:0]; m_valid = 1;
      end
    end else if (m_valid && !stall) begin
      m_valid = 0;
      if (jump_en) begin
        m_pc = jump_addr; m_fetch = 1;
      end else if (m_pc == 4'd15 && !WRAP) begin
        m_halt = 1;
      end else begin
        m_pc = m_pc + 4'd1; m_fetch = 1;
      end
    end
  endtask

  initial begin
    vecs[0] = '{8'h31, 8'h0F, 1'b1, 1'b0, 4'h3, 4'h1};
    vecs[1] = '{8'hA2, 8'h0F, 1'b1, 1'b0, 4'hA, 4'h2};
    vecs[2] = '{8'h0F, 8'h31, 1'b0, 1'b1, 4'h0, 4'h0};
    vecs[3] = '{8'hFE, 8'h0F, 1'b1, 1'b0, 4'hF, 4'hE};
    vecs[4] = '{8'h5F, 8'h12, 1'b0, 1'b1, 4'h0, 4'h0};
    vecs[5] = '{8'h00, 8'h0F, 1'b1, 1'b0, 4'h0, 4'h0};

    #2;
    chk_all("reset", 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    tick();
    reset = 0;

    for (int i = 0; i < 6; i++) begin
      do_reset();
      load(4'd0, vecs[i].w0);
      load(4'd1, vecs[i].w1);
      run = 1;
      tick();
      run = 0;
      tick();
      chk_all($sformatf("vec%0d", i), 4'd0, vecs[i].v, vecs[i].h,
              vecs[i].x, vecs[i].op);
    end

    // basic issue then halt
    do_reset();
    load(4'd0, 8'h31);
    load(4'd1, 8'h0F);
    run = 1; tick(); run = 0;
    chk_all("t1.fetch", 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    tick();
    chk_all("t1.issue", 4'd0, 1'b1, 1'b0, 4'd3, 4'd1);
    tick();
    chk_all("t1.fetch2", 4'd1, 1'b0, 1'b0, 4'd3, 4'd1);
    tick();
    chk_all("t1.halt", 4'd1, 1'b0, 1'b1, 4'd3, 4'd1);

    // stall holds ISSUE
    do_reset();
    load(4'd0, 8'h11);
    load(4'd1, 8'h22);
    load(4'd2, 8'h0F);
    run = 1; tick(); run = 0; tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("t2.stall%0d", i), 4'd0, 1'b1, 1'b0, 4'd1, 4'd1);
    end
    stall = 0;
    tick();
    chk("t2.release.count", 32'(count), 32'd1);
    tick();
    chk_all("t2.next", 4'd1, 1'b1, 1'b0, 4'd2, 4'd2);

    // jump from count 2 to 9
    do_reset();
    load(4'd0, 8'h11);
    load(4'd1, 8'h22);
    load(4'd2, 8'h33);
    load(4'd9, 8'h97);
    load(4'd10, 8'h0F);
    run = 1; tick(); run = 0;
    repeat (5) tick();
    chk_all("t3.at2", 4'd2, 1'b1, 1'b0, 4'd3, 4'd3);
    jump_en = 1; jump_addr = 4'd9;
    tick();
    jump_en = 0;
    chk("t3.jcount", 32'(count), 32'd9);
    tick();
    chk_all("t3.at9", 4'd9, 1'b1, 1'b0, 4'd9, 4'd7);
    stall = 1; jump_en = 1; jump_addr = 4'd3;
    tick();
    chk_all("t3.stalljump", 4'd9, 1'b1, 1'b0, 4'd9, 4'd7);
    stall = 0; jump_en = 0;
    tick();
    chk("t3.inc", 32'(count), 32'd10);
    tick();
    chk_all("t3.halt", 4'd10, 1'b0, 1'b1, 4'd9, 4'd7);

    // end of program without HALT opcode
    do_reset();
    for (int i = 0; i < 16; i++) load(4'(i), {4'(i), 4'h1});
    run = 1; tick(); run = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_all($sformatf("t4.i%0d", i), 4'(i), 1'b1, 1'b0, 4'(i), 4'h1);
      if (i < 15) tick();
    end
    tick();
    if (WRAP) begin
      chk_all("t4.wrap", 4'd0, 1'b0, 1'b0, 4'hF, 4'h1);
      tick();
      chk_all("t4.wrapissue", 4'd0, 1'b1, 1'b0, 4'h0, 4'h1);
    end else begin
      chk_all("t4.end", 4'd15, 1'b0, 1'b1, 4'hF, 4'h1);
      tick();
      chk_all("t4.endhold", 4'd15, 1'b0, 1'b1, 4'hF, 4'h1);
    end

    // async reset during ISSUE
    do_reset();
    load(4'd0, 8'h71);
    run = 1; tick(); run = 0; tick();
    chk_all("t5.first", 4'd0, 1'b1, 1'b0, 4'd7, 4'd1);
    tick(); tick();
    chk_all("t5.second", 4'd1, 1'b1, 1'b0, 4'd1, 4'd1);
    reset = 1;
    #1;
    chk_all("t5.async", 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    #1;
    reset = 0;
    run = 1; tick(); run = 0; tick();
    chk_all("t5.restart", 4'd0, 1'b1, 1'b0, 4'd7, 4'd1);

    // writes and run ignored while running
    do_reset();
    load(4'd0, 8'h71);
    load(4'd1, 8'h82);
    load(4'd2, 8'h0F);
    run = 1; tick(); run = 0; tick();
    prog_we = 1; prog_addr = 4'd0; prog_data = 8'hEE; run = 1;
    tick();
    chk("t6.norestart", 32'(count), 32'd1);
    prog_addr = 4'd1;
    tick();
    chk_all("t6.c1", 4'd1, 1'b1, 1'b0, 4'd8, 4'd2);
    prog_we = 0; run = 0;
    tick(); tick();
    chk_all("t6.halt", 4'd2, 1'b0, 1'b1, 4'd8, 4'd2);
    run = 1; tick(); run = 0; tick();
    chk_all("t6.reread0", 4'd0, 1'b1, 1'b0, 4'd7, 4'd1);
    tick(); tick();
    chk_all("t6.reread1", 4'd1, 1'b1, 1'b0, 4'd8, 4'd2);

    // randomized run against the reference model
    do_reset();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      mm[i] = {4'($urandom_range(0, 15)), op};
      load(4'(i), mm[i]);
    end
    m_idle = 1; m_fetch = 0; m_valid = 0; m_halt = 0;
    m_pc = 0; m_x = 0; m_op = 0;
    for (int c = 0; c < 600; c++) begin
      run       = ($urandom_range(0, 5) == 0);
      stall     = ($urandom_range(0, 2) == 0);
      jump_en   = ($urandom_range(0, 3) == 0);
      jump_addr = 4'($urandom_range(0, 15));
      prog_we   = ($urandom_range(0, 5) == 0);
      prog_addr = 4'($urandom_range(0, 15));
      prog_data = 8'($urandom_range(0, 255));
      if (prog_data[3:0] == 4'hF && $urandom_range(0, 1) == 0)
        prog_data[3:0] = 4'h6;
      model_step();
      tick();
      chk_all($sformatf("rnd%0d", c), m_pc, m_valid, m_halt, m_x, m_op);
    end
    run = 0; stall = 0; jump_en = 0; prog_we = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
